// File: rtl/usb_axis_pkg.sv
// Shared types and widths for the USB-word to AXI4-Stream bridge.
package usb_axis_pkg;
    localparam int USB_WORD_W = 64;
    localparam int AXIS_W     = 32;

    typedef enum logic {
        S_LO = 1'b0,
        S_HI = 1'b1
    } beat_state_t;
endpackage

// File: rtl/usb_axis_bridge_if.sv
// AXI4-Stream beat channel between the bridge and the SoC stream fabric.
interface usb_axis_bridge_if;
    import usb_axis_pkg::*;

    logic [AXIS_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/usb_sync_fifo.sv
// DEPTH x 64 synchronous FIFO with an asynchronously read head word.
// Full/empty are derived from the level count, so pointers may simply wrap.
module usb_sync_fifo
    import usb_axis_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                    axi_clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [USB_WORD_W-1:0]   data_i,
    output logic [USB_WORD_W-1:0]   head_o,
    output logic [$clog2(DEPTH):0]  level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [USB_WORD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;

    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_i  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        unique case ({push_i, pop_i})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; level gates every read of it.
    always_ff @(posedge axi_clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;
endmodule

// File: rtl/usb_axis_bridge.sv
// Buffers valid-only 64-bit USB words and replays each as two 32-bit AXIS beats
// (low half first, tlast on the high half), counting words lost when full.
module usb_axis_bridge
    import usb_axis_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                    axi_clk,
    input  logic                    rst,
    input  logic [USB_WORD_W-1:0]   usb_data_i,
    input  logic                    usb_data_valid_i,
    usb_axis_bridge_if.master       m_axis,
    output logic [$clog2(DEPTH):0]  fifo_level_o,
    output logic                    overflow_o,
    output logic [CNT_W-1:0]        drop_cnt_o,
    input  logic                    clr_i
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    beat_state_t           state_q, state_d;
    logic [USB_WORD_W-1:0] head;
    logic [LW-1:0]         level;
    logic                  tvalid, hs, pop, push, drop;
    logic                  overflow_q, overflow_d;
    logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;

    usb_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .axi_clk (axi_clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (usb_data_i),
        .head_o  (head),
        .level_o (level)
    );

    // A pop at full frees the slot in the same edge, so the word is still taken.
    assign tvalid = (level != '0);
    assign hs     = tvalid & m_axis.tready;
    assign pop    = hs & (state_q == S_HI);
    assign push   = usb_data_valid_i & ((level != FULL) | pop);
    assign drop   = usb_data_valid_i & ~push;

    always_comb begin
        state_d      = state_q;
        m_axis.tdata = '0;
        m_axis.tlast = 1'b0;
        if (hs) state_d = (state_q == S_LO) ? S_HI : S_LO;
        if (tvalid) begin
            if (state_q == S_HI) begin
                m_axis.tdata = head[2*AXIS_W-1:AXIS_W];
                m_axis.tlast = 1'b1;
            end else begin
                m_axis.tdata = head[AXIS_W-1:0];
            end
        end
    end

    // A drop in the clear cycle wins and restarts the count at one.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_i)                 drop_cnt_d = CNT_W'(1);
            else if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end else if (clr_i) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge axi_clk) begin
        if (!rst) begin
            state_q    <= S_LO;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign m_axis.tvalid = tvalid;
    assign fifo_level_o  = level;
    assign overflow_o    = overflow_q;
    assign drop_cnt_o    = drop_cnt_q;
endmodule

// File: tb/tb_usb_axis_bridge.sv
// Directed scoreboard bench: two bridges (CNT_W 16 and 4) share one stimulus stream.
module tb_usb_axis_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] usb_d;
    logic        usb_v;
    logic        clr_p;
    logic [4:0]  lvl_a, lvl_b;
    logic        ovf_a, ovf_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    int n_vec = 0;
    int n_err = 0;
    logic [32:0] sb [$];

    usb_axis_bridge_if ax_a ();
    usb_axis_bridge_if ax_b ();

    always #5 clk = ~clk;

    usb_axis_bridge #(.DEPTH(16), .CNT_W(16)) dut_a (
        .axi_clk(clk), .rst(rst), .usb_data_i(usb_d), .usb_data_valid_i(usb_v),
        .m_axis(ax_a), .fifo_level_o(lvl_a), .overflow_o(ovf_a),
        .drop_cnt_o(cnt_a), .clr_i(clr_p)
    );

    usb_axis_bridge #(.DEPTH(16), .CNT_W(4)) dut_b (
        .axi_clk(clk), .rst(rst), .usb_data_i(usb_d), .usb_data_valid_i(usb_v),
        .m_axis(ax_b), .fifo_level_o(lvl_b), .overflow_o(ovf_b),
        .drop_cnt_o(cnt_b), .clr_i(clr_p)
    );

    function automatic logic [63:0] wd(input int i);
        return {32'hA5000000 | 32'(i), 32'h3C000000 | 32'(i)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic exp_word(input logic [63:0] w);
        sb.push_back({1'b0, w[31:0]});
        sb.push_back({1'b1, w[63:32]});
    endtask

    // Inputs change on the falling edge; the beat offered now is taken at the next rising edge.
    task automatic step(input logic v, input logic [63:0] d, input logic rdy,
                        input logic clr, input logic r);
        logic [32:0] e;
        usb_v = v; usb_d = d; ax_a.tready = rdy; ax_b.tready = rdy; clr_p = clr; rst = r;
        if (!r) begin
            sb.delete();
        end else if (ax_a.tvalid && rdy) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                chk("beat", {31'b0, ax_a.tlast, ax_a.tdata}, {31'b0, e});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 64'h0, rdy, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 80 && sb.size() != 0; i++) idle(1'b1);
        chk(tag, 64'(sb.size()), 64'd0);
        chk({tag, "_lvl"}, 64'(lvl_a), 64'd0);
    endtask

    initial begin
        rst = 1'b0; usb_v = 1'b0; usb_d = '0; clr_p = 1'b0;
        ax_a.tready = 1'b0; ax_b.tready = 1'b0;
        @(negedge clk);

        // 1: reset state and single word
        do_reset();
        chk("rst_tvalid", 64'(ax_a.tvalid), 64'd0);
        chk("rst_tdata",  64'(ax_a.tdata),  64'd0);
        chk("rst_tlast",  64'(ax_a.tlast),  64'd0);
        chk("rst_level",  64'(lvl_a),       64'd0);
        chk("rst_ovf",    64'(ovf_a),       64'd0);
        chk("rst_cnt",    64'(cnt_a),       64'd0);
        exp_word(64'h1122334455667788);
        step(1'b1, 64'h1122334455667788, 1'b1, 1'b0, 1'b1);
        chk("t1_tvalid", 64'(ax_a.tvalid), 64'd1);
        chk("t1_lo",     {31'b0, ax_a.tlast, ax_a.tdata}, {31'b0, 1'b0, 32'h55667788});
        chk("t1_level1", 64'(lvl_a), 64'd1);
        idle(1'b1);
        chk("t1_hi",     {31'b0, ax_a.tlast, ax_a.tdata}, {31'b0, 1'b1, 32'h11223344});
        idle(1'b1);
        chk("t1_level0", 64'(lvl_a), 64'd0);
        chk("t1_sb", 64'(sb.size()), 64'd0);

        // 2: backpressure
        do_reset();
        for (int i = 0; i < 3; i++) begin
            exp_word(wd(i));
            step(1'b1, wd(i), 1'b0, 1'b0, 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            chk("t2_hold", {31'b0, ax_a.tlast, ax_a.tdata}, {31'b0, 1'b0, wd(0) & 64'hFFFFFFFF});
            chk("t2_level", 64'(lvl_a), 64'd3);
            idle(1'b0);
        end
        drain("t2_drain");

        // 3: overflow
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (i < 16) exp_word(wd(100 + i));
            step(1'b1, wd(100 + i), 1'b0, 1'b0, 1'b1);
        end
        chk("t3_level", 64'(lvl_a), 64'd16);
        chk("t3_cnt",   64'(cnt_a), 64'd4);
        chk("t3_ovf",   64'(ovf_a), 64'd1);
        chk("t3_cnt_b", 64'(cnt_b), 64'd4);
        drain("t3_drain");
        chk("t3_ovf_sticky", 64'(ovf_a), 64'd1);

        // 4: pop at full with simultaneous push
        do_reset();
        for (int i = 0; i < 16; i++) begin
            exp_word(wd(200 + i));
            step(1'b1, wd(200 + i), 1'b0, 1'b0, 1'b1);
        end
        idle(1'b1);
        chk("t4_shi", 64'(ax_a.tlast), 64'd1);
        exp_word(wd(216));
        step(1'b1, wd(216), 1'b1, 1'b0, 1'b1);
        chk("t4_level", 64'(lvl_a), 64'd16);
        chk("t4_cnt",   64'(cnt_a), 64'd0);
        chk("t4_ovf",   64'(ovf_a), 64'd0);
        drain("t4_drain");

        // 5: saturation, then clear colliding with a drop, then plain clear
        do_reset();
        for (int i = 0; i < 36; i++) begin
            if (i < 16) exp_word(wd(300 + i));
            step(1'b1, wd(300 + i), 1'b0, 1'b0, 1'b1);
        end
        chk("t5_cnt_a", 64'(cnt_a), 64'd20);
        chk("t5_sat_b", 64'(cnt_b), 64'd15);
        step(1'b1, wd(399), 1'b0, 1'b1, 1'b1);
        chk("t5_clrdrop_cnt", 64'(cnt_a), 64'd1);
        chk("t5_clrdrop_ovf", 64'(ovf_a), 64'd1);
        chk("t5_clrdrop_b",   64'(cnt_b), 64'd1);
        step(1'b0, 64'h0, 1'b0, 1'b1, 1'b1);
        chk("t5_clr_cnt", 64'(cnt_a), 64'd0);
        chk("t5_clr_ovf", 64'(ovf_a), 64'd0);
        drain("t5_drain");

        // 6: reset right after the low-beat handshake
        do_reset();
        exp_word(wd(400));
        step(1'b1, wd(400), 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        chk("t6_in_hi", 64'(ax_a.tlast), 64'd1);
        step(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        chk("t6_tvalid", 64'(ax_a.tvalid), 64'd0);
        chk("t6_level",  64'(lvl_a), 64'd0);
        exp_word(wd(401));
        step(1'b1, wd(401), 1'b0, 1'b0, 1'b1);
        chk("t6_restart_lo", {31'b0, ax_a.tlast, ax_a.tdata}, {31'b0, 1'b0, wd(401) & 64'hFFFFFFFF});
        drain("t6_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
